// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

  // Arbiter FSM: nobody owns the resource, or exactly one requester does.
  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Largest supported requester count.
  localparam int ARB_MAX_N = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Arbiter bus: requesters drive request, the arbiter answers with grant,
// grant_id and busy.
// Handshake: request is level-sensitive and sampled on each rising clk edge;
// grant/grant_id/busy are registered and change only on that edge. A holder
// keeps its grant for as long as it holds its request bit high.
interface rr_grant_arbiter_if #(parameter int N = 2);
  import arb_pkg::*;

  localparam int IDW = idw(N);

  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;

  modport master (output request, input grant, input grant_id, input busy);
  modport slave  (input request, output grant, output grant_id, output busy);
endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// rr_pick: combinational rotating priority encoder.
// Scans last+1, last+2, ... wrapping modulo N and ends with last itself;
// with exclude set, last is skipped so only other requesters can win.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   request,
  input  logic [IDW-1:0] last,
  input  logic           exclude,
  output logic           found,
  output logic [IDW-1:0] winner
);

  int idx;

  // First requester in rotating order after last wins.
  always_comb begin
    found  = 1'b0;
    winner = last;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last) + i;
      if (idx >= N) idx = idx - N;
      if (!found && request[idx[IDW-1:0]] && !(exclude && i == N)) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: synchronous N-way round-robin arbiter.
// Grants are registered one-hot and held while the holder keeps requesting;
// ownership then moves to the next requester after the previous holder.
// Optional build macro ARB_TIMEOUT_EN adds a hold counter that forces
// rotation after MAX_HOLD consecutive cycles when someone else is waiting.
// N must lie in 2..ARB_MAX_N.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_grant_arbiter_if.slave    arb,
  output arb_state_t           state_dbg
);

  localparam int IDW = idw(N);

  arb_state_t     state;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic           busy_q;
  logic [IDW-1:0] last_q;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic           holder_req;
  logic           timeout;
  logic           keep;
  logic           start;

  assign arb.grant    = grant_q;
  assign arb.grant_id = grant_id_q;
  assign arb.busy     = busy_q;
  assign state_dbg    = state;

  // While owned the holder is excluded so the pick only finds other waiters.
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .request (arb.request),
    .last    (last_q),
    .exclude (state == OWNED),
    .found   (pick_found),
    .winner  (pick_id)
  );

  assign holder_req = arb.request[grant_id_q];
  // Holder keeps ownership unless a timeout coincides with another waiter.
  assign keep  = holder_req && !(timeout && pick_found);
  // A new ownership period begins on a fresh grant or a handover.
  assign start = pick_found && ((state == IDLE) || !keep);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;

  assign timeout = (state == OWNED) && (hold_cnt == CW'(MAX_HOLD));

  // Count consecutive cycles of the current holder, saturating at MAX_HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (start) begin
      hold_cnt <= CW'(1);
    end else if (state == OWNED && keep && hold_cnt != CW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Ownership FSM with registered grant, grant_id, busy and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      last_q     <= IDW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= OWNED;
            grant_q    <= N'(1) << pick_id;
            grant_id_q <= pick_id;
            busy_q     <= 1'b1;
            last_q     <= pick_id;
          end
        end
        OWNED: begin
          if (keep) begin
            state <= OWNED;
          end else if (start) begin
            grant_q    <= N'(1) << pick_id;
            grant_id_q <= pick_id;
            last_q     <= pick_id;
          end else begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter with N=2, MAX_HOLD=4. Follows the
// ARB_TIMEOUT_EN macro so the same file covers both builds.
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  localparam int N        = 2;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Expected word: {check_id, busy, grant_id, grant[1:0]}
  localparam logic [4:0] E_RST  = 5'b1_0_0_00;
  localparam logic [4:0] E_IDLE = 5'b0_0_0_00;
  localparam logic [4:0] E_G0   = 5'b1_1_0_01;
  localparam logic [4:0] E_G1   = 5'b1_1_1_10;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst;
  arb_state_t state_dbg;

  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.N(N)) arb_bus ();

  rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb       (arb_bus),
    .state_dbg (state_dbg)
  );

  // Scoreboard
  logic [4:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference model state for the random phase
  logic m_busy;
  logic m_id;
  logic m_last;
  int   m_cnt;

  task automatic check(input string tag);
    logic [4:0] e;
    logic [3:0] got;
    logic [3:0] mask;
    e    = exp_q.pop_front();
    got  = {arb_bus.busy, arb_bus.grant_id, arb_bus.grant};
    mask = e[4] ? 4'b1111 : 4'b1011;
    checks++;
    assert ((got & mask) === (e[3:0] & mask)) passes++;
    else $error("FAIL %s busy/id/grant got=%b exp=%b mask=%b", tag, got, e[3:0], mask);
  endtask

  // Drive one cycle of stimulus at the falling edge, check after the next rise.
  task automatic step(input logic r, input logic [1:0] req, input logic [4:0] exp,
                      input string tag);
    rst = r;
    arb_bus.request = req;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 1'b0;
    m_last = 1'b1;
    m_cnt  = 0;
  endtask

  task automatic model_next(input logic [1:0] req, output logic [4:0] exp);
    logic other;
    logic to;
    if (!m_busy) begin
      if (req != 2'b00) begin
        other  = ~m_last;
        m_id   = req[other] ? other : m_last;
        m_last = m_id;
        m_busy = 1'b1;
        m_cnt  = 1;
      end
    end else begin
      other = ~m_id;
      to    = TO_EN && (m_cnt == MAX_HOLD);
      if (req[m_id] && !(to && req[other])) begin
        if (m_cnt < MAX_HOLD) m_cnt++;
      end else if (req[other]) begin
        m_id   = other;
        m_last = other;
        m_cnt  = 1;
      end else begin
        m_busy = 1'b0;
      end
    end
    exp = m_busy ? (m_id ? E_G1 : E_G0) : E_IDLE;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Directed then random stimulus
  initial begin
    logic [1:0] rq;
    logic [4:0] ex;
    rst = 1'b1;
    arb_bus.request = 2'b00;
    @(negedge clk);

    // Reset held with both requesting, then first grant to requester 0
    step(1'b1, 2'b11, E_RST, "reset_hold_1");
    step(1'b1, 2'b11, E_RST, "reset_hold_2");
    step(1'b0, 2'b11, E_G0,  "first_after_reset");

    // Single request, grant held
    step(1'b1, 2'b00, E_RST, "reset_again");
    step(1'b0, 2'b01, E_G0,  "single_grant");
    step(1'b0, 2'b01, E_G0,  "single_hold");

    // Handover with no idle gap, then release
    step(1'b0, 2'b10, E_G1,   "handover");
    step(1'b0, 2'b00, E_IDLE, "release_idle");

    // Fairness: each holder drops for a cycle, the other re-requests
    step(1'b0, 2'b11, E_G0, "fair_0");
    step(1'b0, 2'b10, E_G1, "fair_1");
    step(1'b0, 2'b01, E_G0, "fair_2");
    step(1'b0, 2'b10, E_G1, "fair_3");
    step(1'b0, 2'b01, E_G0, "fair_4");
    step(1'b0, 2'b11, E_G0, "fair_hold_0");
    step(1'b0, 2'b10, E_G1, "fair_5");
    step(1'b0, 2'b11, E_G1, "fair_hold_1");

    // Pointer decides simultaneous requests from idle
    step(1'b0, 2'b00, E_IDLE, "ptr_idle_a");
    step(1'b0, 2'b11, E_G0,   "ptr_after_1");
    step(1'b0, 2'b00, E_IDLE, "ptr_idle_b");
    step(1'b0, 2'b11, E_G1,   "ptr_after_0");
    step(1'b0, 2'b00, E_IDLE, "ptr_idle_c");

    // Both held high: rotation every MAX_HOLD cycles only with the timeout build
    for (int k = 0; k < 12; k++)
      step(1'b0, 2'b11, (!TO_EN || ((k / 4) % 2 == 0)) ? E_G0 : E_G1, "timeout_rot");

    // Lone holder never loses its grant
    for (int k = 0; k < 6; k++)
      step(1'b0, 2'b01, E_G0, "lone_holder");
    step(1'b0, 2'b00, E_IDLE, "lone_release");

    // Mid-operation reset restores the pointer
    step(1'b0, 2'b10, E_G1,  "pre_reset_grant");
    step(1'b1, 2'b11, E_RST, "mid_reset");
    step(1'b0, 2'b11, E_G0,  "post_reset_ptr");

    // Random traffic against the reference model
    step(1'b1, 2'b00, E_RST, "rand_reset");
    model_reset();
    for (int k = 0; k < 60; k++) begin
      rq = 2'($urandom_range(0, 3));
      model_next(rq, ex);
      step(1'b0, rq, ex, "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Synchronous N-way round-robin arbiter that owns the responder side of the arbiter interface. It samples `request`, issues a registered one-hot `grant`, and holds that grant while the holder keeps requesting. Ownership then passes to the next requester in rotating order. It is the design-side block behind the arbiter interface, bound to the same `clk` and `rst` signals that the arbiter testbench drives.

## Interface
- `N`, default 2: number of requesters; legal range is 2 to 16.
- `MAX_HOLD`, default 8: maximum number of consecutive grant cycles before a forced rotation. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `request`  in  N: one bit per requester. Level-sensitive.
- `grant`  out  N: one-hot or all-zero, registered.
- `grant_id`  out  IDW: index of the current holder, where IDW = max(1, $clog2(N)). The value is valid only while `busy` is 1.
- `busy`  out  1: 1 while any grant is asserted.

## Operation
- FSM states are IDLE and OWNED.
  - IDLE: `grant` = 0 and `busy` = 0.
  - OWNED: exactly one `grant` bit is set.
- Round-robin pointer `last`:
  - `last` holds the index of the most recent holder.
  - Search order is `last`+1, `last`+2, …, wrapping modulo N, and ends with `last` itself.
  - Reset sets `last` to N-1, so requester 0 has top priority after reset.
- IDLE transitions:
  - If `request` ≠ 0, go to OWNED, grant the first requester in search order, and update `last` to the winner.
  - If `request` = 0, stay in IDLE.
- OWNED transitions, evaluated at every edge:
  - Holder's `request` bit still 1 and no timeout: keep the grant unchanged.
  - Holder's bit is 0 and other requests are pending: hand over in the same edge to the next requester in search order. There is no idle cycle between holders.
  - Holder's bit is 0 and no requests are pending: go to IDLE.
- Simultaneous requests are resolved only by the pointer. Requester index carries no fixed priority.
- A request that rises and falls between two edges is never seen.
- Reset mid-grant: `grant` clears at that edge, and the FSM and pointer return to their reset values.

## Timing
- Reset values: `grant` = 0, `grant_id` = 0, `busy` = 0, state IDLE, `last` = N-1, hold counter = 0.
- Latency:
  - A request sampled at edge k produces a grant that is visible after edge k. It is therefore readable one cycle later, and a check two edges after driving the request is also valid.
- Release:
  - The holder drops its request before edge k.
  - The grant deasserts, or hands over, after edge k.
- `grant`, `grant_id` and `busy` are all flops. There is no combinational path from `request` to `grant`.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- When defined:
  - A hold counter of width $clog2(MAX_HOLD+1) counts the holder's cycles. It starts at 1 on the grant edge.
  - When the count reaches `MAX_HOLD` and at least one other request is pending, the grant is forced to the next requester in search order at the following edge, and the counter restarts at 1.
  - With no other request pending, the holder keeps the grant and the counter saturates at `MAX_HOLD`.
- When not defined:
  - No counter is built.
  - The holder keeps the grant for as long as its request stays high.

## Structure
- Package `arb_pkg` contains:
  - The state enum (IDLE, OWNED).
  - `ARB_MAX_N` = 16.
  - An IDW helper function.
- Sub-module `rr_pick` is a combinational rotating priority encoder.
  - Inputs: `request[N-1:0]`, `last`, and an exclude-holder flag.
  - Outputs: `found` and a winner index.
  - The top module contains the FSM, the registers and the timeout counter.

## Test plan
- Reset then idle: hold `rst` = 1 for 2 edges with `request` = 2'b11 → `grant` = 00 and `busy` = 0. At the first edge after reset release → `grant` = 01 and `grant_id` = 0.
- Single request: `request` = 2'b01 after reset → `grant` = 01 one edge later. Check `grant` = 01 again two edges after driving; it must be unchanged.
- Handover: hold 01 granted, drive `request` = 2'b10, so bit 0 drops → next edge `grant` = 10 with no zero cycle between holders.
- Fairness: `request` = 2'b11, each holder drops for one cycle after each grant → grant sequence 01, 10, 01, 10. Re-request at the same edge the holder drops → each requester is granted once every other grant; neither is starved.
- Timeout: with `ARB_TIMEOUT_EN`, `MAX_HOLD` = 4 and `request` = 2'b11 held high → `grant` is 01 for 4 cycles, then 10 for 4 cycles, then 01. Without the macro → `grant` stays 01.
- Mid-operation reset: with `grant` = 10, assert `rst` for one edge → `grant` = 00. If `request` = 11 after release → `grant` = 01, because the pointer was reset.
